trap_csr: RTL and testbench

- Machine-mode trap CSR file: the consumer side of the trap-control handshake.
- Accepts trap_taken/trap_src/trap_return from the jump unit and commits trap entry/exit state (mepc, mcause, mtval, mstatus).
- Supplies mtvec_rdata/mepc_rdata back to the jump unit and raises the gated, synchronized external_int request.
- Also services CSR read/modify/write instructions and runs mcycle/minstret counters.

---
 rtl/trap_csr.sv | 184 ++++++++++++++++++
 tb/tb_trap_csr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_csr.sv
// Machine-mode trap CSR file: commits trap entry/exit state and services CSR
// read/modify/write instructions. Also runs the mcycle/minstret counters and
// synchronizes the external interrupt line.
module trap_csr #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ext_irq_i,
  input  logic        csr_en_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        trap_taken_i,
  input  logic        trap_return_i,
  input  logic [4:0]  trap_src_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_val_i,
  input  logic        instret_i,
  output logic [31:0] mtvec_rdata_o,
  output logic [31:0] mepc_rdata_o,
  output logic        external_int_o
);

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMie       = 12'h304;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMscratch  = 12'h340;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMtval     = 12'h343;
  localparam logic [11:0] AddrMip       = 12'h344;
  localparam logic [11:0] AddrMcycle    = 12'hB00;
  localparam logic [11:0] AddrMinstret  = 12'hB02;
  localparam logic [11:0] AddrMcycleh   = 12'hB80;
  localparam logic [11:0] AddrMinstreth = 12'hB82;

  localparam logic [1:0] OpNone = 2'b00;
  localparam logic [1:0] OpRw   = 2'b01;
  localparam logic [1:0] OpRs   = 2'b10;

  logic        mie_q, mie_d;       // mstatus.MIE
  logic        mpie_q, mpie_d;     // mstatus.MPIE
  logic        meie_q, meie_d;     // mie.MEIE
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  logic        meip;
  logic        addr_ok;
  logic        mip_wr_bad;
  logic        csr_we;
  logic [31:0] new_val;

  assign meip           = sync_q[SYNC_STAGES-1];
  assign external_int_o = meip & meie_q & mie_q;
  assign mtvec_rdata_o  = mtvec_q;
  assign mepc_rdata_o   = mepc_q;
  assign sync_d         = {sync_q[SYNC_STAGES-2:0], ext_irq_i};

  // Read mux: old value of the addressed CSR plus address legality.
  always_comb begin
    csr_rdata_o = 32'h0;
    addr_ok     = 1'b1;
    case (csr_addr_i)
      AddrMstatus:   csr_rdata_o = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      AddrMie:       csr_rdata_o = {20'b0, meie_q, 11'b0};
      AddrMtvec:     csr_rdata_o = mtvec_q;
      AddrMscratch:  csr_rdata_o = mscratch_q;
      AddrMepc:      csr_rdata_o = mepc_q;
      AddrMcause:    csr_rdata_o = mcause_q;
      AddrMtval:     csr_rdata_o = mtval_q;
      AddrMip:       csr_rdata_o = {20'b0, meip, 11'b0};
      AddrMcycle:    csr_rdata_o = mcycle_q[31:0];
      AddrMcycleh:   csr_rdata_o = mcycle_q[63:32];
      AddrMinstret:  csr_rdata_o = minstret_q[31:0];
      AddrMinstreth: csr_rdata_o = minstret_q[63:32];
      default:       addr_ok     = 1'b0;
    endcase
  end

  // mip is read-only; a set/clear with a zero mask is a pure read and stays legal.
  assign mip_wr_bad    = (csr_addr_i == AddrMip) &&
                         ((csr_op_i == OpRw) || ((csr_op_i != OpNone) && (csr_wdata_i != 32'h0)));
  assign csr_illegal_o = csr_en_i && (!addr_ok || mip_wr_bad);
  // Any trap activity in the same cycle drops the CSR write.
  assign csr_we        = csr_en_i && (csr_op_i != OpNone) && !csr_illegal_o && !trap_taken_i;

  // Read-modify-write value.
  always_comb begin
    new_val = csr_rdata_o & ~csr_wdata_i;
    if (csr_op_i == OpRw)      new_val = csr_wdata_i;
    else if (csr_op_i == OpRs) new_val = csr_rdata_o | csr_wdata_i;
  end

  // Next-state for architectural CSRs: trap update takes priority over CSR writes.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_taken_i && !trap_return_i) begin
      mepc_d   = {trap_pc_i[31:2], 2'b00};
      mcause_d = {trap_src_i[4], 27'b0, trap_src_i[3:0]};
      mtval_d  = trap_val_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (trap_taken_i && trap_return_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr_i)
        AddrMstatus: begin
          mie_d  = new_val[3];
          mpie_d = new_val[7];
        end
        AddrMie:      meie_d     = new_val[11];
        AddrMtvec:    mtvec_d    = {new_val[31:2], 2'b00};
        AddrMscratch: mscratch_d = new_val;
        AddrMepc:     mepc_d     = {new_val[31:2], 2'b00};
        AddrMcause:   mcause_d   = {new_val[31], 27'b0, new_val[3:0]};
        AddrMtval:    mtval_d    = new_val;
        default: ;
      endcase
    end
  end

  // Counter next-state: a write to either half replaces it and skips that counter's increment.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instret_i};
    if (csr_we) begin
      case (csr_addr_i)
        AddrMcycle:    mcycle_d   = {mcycle_q[63:32], new_val};
        AddrMcycleh:   mcycle_d   = {new_val, mcycle_q[31:0]};
        AddrMinstret:  minstret_d = {minstret_q[63:32], new_val};
        AddrMinstreth: minstret_d = {new_val, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= {RESET_MTVEC[31:2], 2'b00};
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
      sync_q     <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      meie_q     <= meie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      sync_q     <= sync_d;
    end
  end

endmodule

// File: tb/tb_trap_csr.sv
// Directed bench for trap_csr with hand-computed expected values.
module tb_trap_csr;

  localparam logic [31:0] ResetMtvec = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_taken;
  logic        trap_return;
  logic [4:0]  trap_src;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        instret;
  logic [31:0] mtvec_rdata;
  logic [31:0] mepc_rdata;
  logic        external_int;

  int n_vec = 0;
  int n_err = 0;

  trap_csr #(
    .RESET_MTVEC (ResetMtvec),
    .SYNC_STAGES (2)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ext_irq_i      (ext_irq),
    .csr_en_i       (csr_en),
    .csr_op_i       (csr_op),
    .csr_addr_i     (csr_addr),
    .csr_wdata_i    (csr_wdata),
    .csr_rdata_o    (csr_rdata),
    .csr_illegal_o  (csr_illegal),
    .trap_taken_i   (trap_taken),
    .trap_return_i  (trap_return),
    .trap_src_i     (trap_src),
    .trap_pc_i      (trap_pc),
    .trap_val_i     (trap_val),
    .instret_i      (instret),
    .mtvec_rdata_o  (mtvec_rdata),
    .mepc_rdata_o   (mepc_rdata),
    .external_int_o (external_int)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_en    = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wd;
  endtask

  task automatic trap(input logic ret, input logic [4:0] src, input logic [31:0] pc,
                      input logic [31:0] val);
    trap_taken  = 1'b1;
    trap_return = ret;
    trap_src    = src;
    trap_pc     = pc;
    trap_val    = val;
  endtask

  task automatic idle();
    csr_en      = 1'b0;
    csr_op      = 2'b00;
    csr_wdata   = 32'h0;
    trap_taken  = 1'b0;
    trap_return = 1'b0;
  endtask

  // Combinational read of a CSR with no instruction issued.
  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #0.5;
    check_eq(tag, csr_rdata, exp);
  endtask

  initial begin
    rst = 1'b1; ext_irq = 1'b0; instret = 1'b0; csr_addr = 12'h0;
    trap_src = 5'h0; trap_pc = 32'h0; trap_val = 32'h0;
    idle();
    #12 rst = 1'b0;
    step();

    // Build up state, then reset mid-cycle.
    csr(2'b01, 12'h340, 32'h0000_0055); step();
    csr(2'b01, 12'h304, 32'h0000_0800); step();
    csr(2'b01, 12'h300, 32'h0000_0008); ext_irq = 1'b1; step();
    idle(); step();
    rd("pre_rst_mscratch", 12'h340, 32'h0000_0055);
    check_eq("pre_rst_ext_int", {31'b0, external_int}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check_eq("rst_mtvec", mtvec_rdata, ResetMtvec);
    check_eq("rst_mepc", mepc_rdata, 32'h0);
    check_eq("rst_ext_int", {31'b0, external_int}, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mscratch", 12'h340, 32'h0);
    ext_irq = 1'b0;
    #1 rst = 1'b0;
    step();

    // ECALL entry and mret.
    csr(2'b01, 12'h300, 32'h0000_0008); step();
    idle();
    rd("mie_set", 12'h300, 32'h0000_1808);
    trap(1'b0, 5'h0B, 32'h0000_0123, 32'h0); step();
    idle();
    check_eq("ecall_mepc", mepc_rdata, 32'h0000_0120);
    rd("ecall_mcause", 12'h342, 32'h0000_000B);
    rd("ecall_mstatus", 12'h300, 32'h0000_1880);
    trap(1'b1, 5'h00, 32'h0, 32'h0); step();
    idle();
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    check_eq("mret_mepc", mepc_rdata, 32'h0000_0120);

    // External interrupt path.
    csr(2'b01, 12'h304, 32'h0000_0800); step();
    csr(2'b01, 12'h300, 32'h0000_0008); step();
    idle();
    check_eq("irq_idle", {31'b0, external_int}, 32'h0);
    ext_irq = 1'b1; step();
    check_eq("irq_edge1", {31'b0, external_int}, 32'h0);
    step();
    check_eq("irq_edge2", {31'b0, external_int}, 32'h1);
    rd("mip_read", 12'h344, 32'h0000_0800);
    trap(1'b0, 5'h1B, 32'h0000_0400, 32'h0); step();
    idle();
    rd("irq_mcause", 12'h342, 32'h8000_000B);
    check_eq("irq_masked", {31'b0, external_int}, 32'h0);
    check_eq("irq_mepc", mepc_rdata, 32'h0000_0400);
    ext_irq = 1'b0;
    csr(2'b01, 12'h344, 32'h0); #1;
    check_eq("mip_rw_ill", {31'b0, csr_illegal}, 32'h1);
    csr(2'b10, 12'h344, 32'h0); #1;
    check_eq("mip_rs0_ok", {31'b0, csr_illegal}, 32'h0);
    csr(2'b11, 12'h344, 32'h1); #1;
    check_eq("mip_rc1_ill", {31'b0, csr_illegal}, 32'h1);
    idle(); step();

    // mscratch RW/RS/RC and an unimplemented address.
    csr(2'b01, 12'h340, 32'hF0F0_F0F0); step(); idle();
    rd("scr_rw", 12'h340, 32'hF0F0_F0F0);
    csr(2'b10, 12'h340, 32'h0000_000F); step(); idle();
    rd("scr_rs", 12'h340, 32'hF0F0_F0FF);
    csr(2'b11, 12'h340, 32'hF000_0000); step(); idle();
    rd("scr_rc", 12'h340, 32'h00F0_F0FF);
    csr(2'b01, 12'h7C0, 32'h0000_1234); #1;
    check_eq("unimpl_ill", {31'b0, csr_illegal}, 32'h1);
    check_eq("unimpl_rdata", csr_rdata, 32'h0);
    step(); idle();
    rd("scr_kept", 12'h340, 32'h00F0_F0FF);
    csr(2'b01, 12'h342, 32'hFFFF_FFFF); step(); idle();
    rd("mcause_mask", 12'h342, 32'h8000_000F);
    csr(2'b01, 12'h305, 32'h0000_0123); step(); idle();
    check_eq("mtvec_align", mtvec_rdata, 32'h0000_0120);

    // CSR write colliding with trap entry.
    csr(2'b01, 12'h341, 32'h0000_0040);
    trap(1'b0, 5'h02, 32'h0000_0200, 32'h0000_DEAD); #1;
    check_eq("coll_old_rd", csr_rdata, 32'h0000_0400);
    step(); idle();
    check_eq("coll_mepc", mepc_rdata, 32'h0000_0200);
    rd("coll_mtval", 12'h343, 32'h0000_DEAD);
    csr(2'b01, 12'h341, 32'h0000_0047); step(); idle();
    check_eq("mepc_wr", mepc_rdata, 32'h0000_0044);

    // Counter wrap.
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF); step();
    csr(2'b01, 12'hB80, 32'hFFFF_FFFF); step(); idle();
    rd("cyc_lo_set", 12'hB00, 32'hFFFF_FFFF);
    rd("cyc_hi_set", 12'hB80, 32'hFFFF_FFFF);
    step();
    rd("cyc_lo_wrap", 12'hB00, 32'h0);
    rd("cyc_hi_wrap", 12'hB80, 32'h0);
    step();
    rd("cyc_lo_inc", 12'hB00, 32'h1);

    // minstret: never advanced since the mid-run reset.
    rd("inst_zero", 12'hB02, 32'h0);
    instret = 1'b1; step(); step(); step();
    instret = 1'b0;
    rd("inst_three", 12'hB02, 32'h3);
    instret = 1'b1;
    csr(2'b01, 12'hB02, 32'h0000_0010); step();
    instret = 1'b0; idle();
    rd("inst_wr_supp", 12'hB02, 32'h0000_0010);
    rd("insth_zero", 12'hB82, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
